// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC front-end and rotator.
// Angles are signed radians in Q.10.
package cordic_pkg;

    localparam int ANGLE_FRAC    = 10;
    localparam int REDUCE_STEPS  = 19;
    localparam int CORDIC_STAGES = 16;

    localparam logic signed [31:0] TWO_PI_Q  = 32'sd6434;
    localparam logic signed [31:0] PI_Q      = 32'sd3217;
    localparam logic signed [31:0] HALF_PI_Q = 32'sd1608;

    // atan(2^-i) in Q.10, consumed by the rotator stages
    localparam logic signed [31:0] ATAN_TAB [CORDIC_STAGES] = '{
        32'sd804, 32'sd475, 32'sd251, 32'sd127, 32'sd64, 32'sd32, 32'sd16, 32'sd8,
        32'sd4,   32'sd2,   32'sd1,   32'sd0,   32'sd0,  32'sd0,  32'sd0,  32'sd0
    };

    typedef enum logic [1:0] {
        IDLE,
        REDUCE,
        FOLD
    } state_t;

    function automatic logic [31:0] two_pi_shifted(input logic [4:0] k);
        logic [31:0] base;
        base = TWO_PI_Q;
        return base << k;
    endfunction

endpackage

// File: rtl/cordic_prerotate_if.sv
// Request/response bundle between the requester, the pre-rotator
// and the rotator inputs.
interface cordic_prerotate_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] x_in;
    logic signed [31:0] y_in;
    logic signed [31:0] z_in;
    logic signed [31:0] x0;
    logic signed [31:0] y0;
    logic signed [31:0] z0;
    logic               out_valid;

    modport master (
        output in_valid, x_in, y_in, z_in,
        input  in_ready, x0, y0, z0, out_valid
    );

    modport slave (
        input  in_valid, x_in, y_in, z_in,
        output in_ready, x0, y0, z0, out_valid
    );
endinterface

// File: rtl/cordic_prerotate_angle_fold.sv
// Combinational fold of a reduced magnitude into [-pi/2, pi/2]:
// sign restore, +/-2pi wrap, +/-pi pre-rotation with vector negation.
module angle_fold
    import cordic_pkg::*;
(
    input  logic               sign,
    input  logic [31:0]        mag,
    input  logic signed [31:0] x_in,
    input  logic signed [31:0] y_in,
    output logic signed [31:0] x_out,
    output logic signed [31:0] y_out,
    output logic signed [31:0] z_out
);

   logic signed [31:0] r_signed;
   logic signed [31:0] r_wrap;
   logic               flip;

   always_comb begin
      r_signed = sign ? -$signed(mag) : $signed(mag);
      r_wrap   = r_signed;
      if (r_signed > PI_Q)
         r_wrap = r_signed - TWO_PI_Q;
      else if (r_signed <= -PI_Q)
         r_wrap = r_signed + TWO_PI_Q;

      // A pi rotation is the same as negating the start vector
      flip  = 1'b0;
      z_out = r_wrap;
      if (r_wrap > HALF_PI_Q) begin
         z_out = r_wrap - PI_Q;
         flip  = 1'b1;
      end else if (r_wrap < -HALF_PI_Q) begin
         z_out = r_wrap + PI_Q;
         flip  = 1'b1;
      end

      x_out = flip ? -x_in : x_in;
      y_out = flip ? -y_in : y_in;
   end

endmodule

// File: rtl/cordic_prerotate.sv
// Angle range reduction ahead of the CORDIC rotator: iterative modulo-2pi
// by restoring subtraction, then a single fold cycle producing x0/y0/z0.
module cordic_prerotate
    import cordic_pkg::*;
#(
    parameter int REDUCE_STEPS = cordic_pkg::REDUCE_STEPS
) (
    input  logic                clk,
    input  logic                rst_n,
    cordic_prerotate_if.slave   bus
);

   localparam int CNT_W = $clog2(REDUCE_STEPS);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   step_reg;
   logic [31:0]        mag_reg;
   logic               sign_reg;
   logic signed [31:0] x_reg, y_reg;
   logic signed [31:0] x0_reg, y0_reg, z0_reg;
   logic               out_valid_reg;
   logic [31:0]        sub_val;
   logic signed [31:0] fold_x, fold_y, fold_z;

   assign sub_val = two_pi_shifted(5'(step_reg));

   angle_fold u_fold (
      .sign  (sign_reg),
      .mag   (mag_reg),
      .x_in  (x_reg),
      .y_in  (y_reg),
      .x_out (fold_x),
      .y_out (fold_y),
      .z_out (fold_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.in_valid) state_next = REDUCE;
         REDUCE:  if (step_reg == '0) state_next = FOLD;
         FOLD:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_reg      <= '0;
         mag_reg       <= '0;
         sign_reg      <= 1'b0;
         x_reg         <= '0;
         y_reg         <= '0;
         x0_reg        <= '0;
         y0_reg        <= '0;
         z0_reg        <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         out_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: if (bus.in_valid) begin
               x_reg    <= bus.x_in;
               y_reg    <= bus.y_in;
               sign_reg <= bus.z_in[31];
               // -0x80000000 wraps to itself, which is 2^31 read unsigned
               mag_reg  <= bus.z_in[31] ? $unsigned(-bus.z_in) : $unsigned(bus.z_in);
               step_reg <= CNT_W'(REDUCE_STEPS - 1);
            end
            REDUCE: begin
               if (mag_reg >= sub_val)
                  mag_reg <= mag_reg - sub_val;
               step_reg <= step_reg - CNT_W'(1);
            end
            FOLD: begin
               x0_reg        <= fold_x;
               y0_reg        <= fold_y;
               z0_reg        <= fold_z;
               out_valid_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.x0        = x0_reg;
   assign bus.y0        = y0_reg;
   assign bus.z0        = z0_reg;
   assign bus.out_valid = out_valid_reg;

endmodule
